// File: rtl/mem_port_arbiter.sv
// Shares one main-memory word port between I-cache refills and D-cache refills/write-backs,
// sequencing each line as a fixed-length burst and raising the pipeline-wide cache stall.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic [DATA_WIDTH-1:0] ic_rdata_o,
  output logic                  ic_rvalid_o,
  output logic                  ic_done_o,
  input  logic                  dc_req_i,
  input  logic                  dc_we_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [DATA_WIDTH-1:0] dc_wdata_i,
  output logic                  dc_wnext_o,
  output logic [DATA_WIDTH-1:0] dc_rdata_o,
  output logic                  dc_rvalid_o,
  output logic                  dc_done_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  cache_stall_o
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W  = BEAT_W + BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t                state, state_next;
  owner_t                owner, last_owner, grant;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_WIDTH-1:0] base;
  logic                  we;
  logic [ADDR_WIDTH-1:0] grant_addr;

  // Round robin on a tie: the side that did not own the last burst wins.
  always_comb begin
    if (ic_req_i && dc_req_i) grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
    else if (dc_req_i)        grant = OWN_D;
    else                      grant = OWN_I;
    grant_addr = (grant == OWN_D) ? dc_addr_i : ic_addr_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      beat       <= '0;
      base       <= '0;
      we         <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (ic_req_i || dc_req_i) begin
          owner      <= grant;
          last_owner <= grant;
          beat       <= '0;
          base       <= grant_addr & LINE_MASK;
          we         <= (grant == OWN_D) && dc_we_i;
        end
        BURST: if (mem_ack_i) beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no branch can infer a latch.
    state_next    = state;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    ic_rdata_o    = '0;
    ic_rvalid_o   = 1'b0;
    ic_done_o     = 1'b0;
    dc_rdata_o    = '0;
    dc_rvalid_o   = 1'b0;
    dc_wnext_o    = 1'b0;
    dc_done_o     = 1'b0;
    cache_stall_o = 1'b0;
    case (state)
      IDLE: if (ic_req_i || dc_req_i) begin
        state_next    = BURST;
        cache_stall_o = 1'b1;
      end
      BURST: begin
        cache_stall_o = 1'b1;
        mem_req_o     = 1'b1;
        mem_we_o      = (owner == OWN_D) && we;
        mem_addr_o    = base + (ADDR_WIDTH'(beat) << BYTE_W);
        mem_wdata_o   = dc_wdata_i;
        if (mem_ack_i) begin
          if (owner == OWN_I) begin
            ic_rvalid_o = 1'b1;
            ic_rdata_o  = mem_rdata_i;
          end else if (we) begin
            dc_wnext_o = 1'b1;
          end else begin
            dc_rvalid_o = 1'b1;
            dc_rdata_o  = mem_rdata_i;
          end
          if (beat == LAST_BEAT) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
        if (owner == OWN_I) begin
          ic_done_o     = 1'b1;
          cache_stall_o = dc_req_i;
        end else begin
          dc_done_o     = 1'b1;
          cache_stall_o = ic_req_i;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
